// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// FSM state type and small request-classification helpers.
package mem_pkg;

  // Access sizes, encoded as the load/store funct3 field
  localparam logic [2:0] MEM_SIZE_B  = 3'b000;
  localparam logic [2:0] MEM_SIZE_H  = 3'b001;
  localparam logic [2:0] MEM_SIZE_W  = 3'b010;
  localparam logic [2:0] MEM_SIZE_BU = 3'b100;
  localparam logic [2:0] MEM_SIZE_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } mem_state_t;

  // Halfwords need an even address, words need a 4-byte aligned address.
  // Bytes are never misaligned; illegal sizes are handled separately.
  function automatic logic mem_is_misaligned(input logic [2:0] size,
                                             input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      MEM_SIZE_H, MEM_SIZE_HU: mis = addr_lo[0];
      MEM_SIZE_W:              mis = (addr_lo != 2'b00);
      default:                 mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Size encodings 011/110/111 are never legal; the unsigned variants are
  // meaningful for loads only.
  function automatic logic mem_size_legal(input logic [2:0] size,
                                          input logic       write);
    logic ok;
    ok = 1'b0;
    case (size)
      MEM_SIZE_B, MEM_SIZE_H, MEM_SIZE_W: ok = 1'b1;
      MEM_SIZE_BU, MEM_SIZE_HU:           ok = !write;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte enables plus replicated store
// data, and the sign/zero-extended load value picked out of a memory word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_shifted,
  output logic [31:0] load_value
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and halfword out of the word
  always_comb begin
    sel_byte = rword[8*addr_lo +: 8];
    sel_half = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  // Store data is replicated across all lanes, so only the byte enables
  // depend on the address; load data is extended per access size.
  always_comb begin
    byte_en       = 4'b0000;
    wdata_shifted = 32'h0;
    load_value    = 32'h0;
    case (size)
      MEM_SIZE_B: begin
        byte_en       = 4'b0001 << addr_lo;
        wdata_shifted = {4{wdata[7:0]}};
        load_value    = {{24{sel_byte[7]}}, sel_byte};
      end
      MEM_SIZE_H: begin
        byte_en       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_shifted = {2{wdata[15:0]}};
        load_value    = {{16{sel_half[15]}}, sel_half};
      end
      MEM_SIZE_W: begin
        byte_en       = 4'b1111;
        wdata_shifted = wdata;
        load_value    = rword;
      end
      MEM_SIZE_BU: load_value = {24'h0, sel_byte};
      MEM_SIZE_HU: load_value = {16'h0, sel_half};
      default: begin
        byte_en       = 4'b0000;
        wdata_shifted = 32'h0;
        load_value    = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory target with valid/ready request and response
// handshakes. Holds the FSM, wait counter, request latch, per-lane storage
// and the response registers.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST =
    CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
  localparam logic [32:0] ADDR_LIMIT = 33'(64'(DEPTH_WORDS) * 64'd4);

  mem_state_t        state_reg;
  logic [CNT_W-1:0]  wait_cnt_reg;
  logic              write_reg;
  logic [2:0]        size_reg;
  logic [31:0]       addr_reg;
  logic [31:0]       wdata_reg;
  logic              err_pend_reg;
  logic              req_ready_reg;
  logic              rsp_valid_reg;
  logic [31:0]       rsp_rdata_reg;
  logic              rsp_error_reg;
  logic [31:0]       ram_q;

  logic              accept;
  logic              exec_error;
  logic              commit;
  logic [IDX_W-1:0]  word_idx;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_shifted;
  logic [31:0]       load_value;

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_error = rsp_error_reg;

  assign accept   = (state_reg == IDLE) && req_valid && req_ready_reg;
  assign word_idx = addr_reg[IDX_W+1:2];

  // Classify the latched request; evaluated while in EXEC
  always_comb begin
    exec_error = !mem_size_legal(size_reg, write_reg)
               || mem_is_misaligned(size_reg, addr_reg[1:0])
               || ({1'b0, addr_reg} >= ADDR_LIMIT);
    commit     = (state_reg == EXEC) && write_reg && !exec_error;
  end

  mem_lane_align u_lane_align (
    .size          (size_reg),
    .addr_lo       (addr_reg[1:0]),
    .wdata         (wdata_reg),
    .rword         (ram_q),
    .byte_en       (byte_en),
    .wdata_shifted (wdata_shifted),
    .load_value    (load_value)
  );

  // One RAM per byte lane so each lane has its own write enable; reads are
  // registered and launched in EXEC, so the word is ready on RESP entry.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      // Byte-lane write on commit and registered read in EXEC
      always_ff @(posedge clk) begin
        if (commit && byte_en[gi]) begin
          lane_mem[word_idx] <= wdata_shifted[8*gi +: 8];
        end
        if (state_reg == EXEC) begin
          ram_q[8*gi +: 8] <= lane_mem[word_idx];
        end
      end
    end
  endgenerate

  // Control FSM: request latch, wait counting and response registers. The
  // first RESP cycle (rsp_valid still low) turns the RAM word into the
  // extended load result; later RESP cycles hold until rsp_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      write_reg     <= 1'b0;
      size_reg      <= 3'b000;
      addr_reg      <= 32'h0;
      wdata_reg     <= 32'h0;
      err_pend_reg  <= 1'b0;
      req_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'h0;
      rsp_error_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          req_ready_reg <= 1'b1;
          if (accept) begin
            write_reg     <= req_write;
            size_reg      <= req_size;
            addr_reg      <= req_addr;
            wdata_reg     <= req_wdata;
            req_ready_reg <= 1'b0;
            wait_cnt_reg  <= '0;
            state_reg     <= (WAIT_STATES == 0) ? EXEC : WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt_reg == WAIT_LAST) begin
            wait_cnt_reg <= '0;
            state_reg    <= EXEC;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        EXEC: begin
          err_pend_reg <= exec_error;
          state_reg    <= RESP;
        end
        RESP: begin
          if (!rsp_valid_reg) begin
            rsp_valid_reg <= 1'b1;
            rsp_error_reg <= err_pend_reg;
            rsp_rdata_reg <= (err_pend_reg || write_reg) ? 32'h0 : load_value;
          end else if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'h0;
            rsp_error_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
